vfilter_ntap: RTL and testbench
===============================

// Module: vfilter_ntap
// PURPOSE
//  Parametrised vertical FIR stage for the 2D filter: TAP_NUMS column pixels in, one filtered pixel out.
//  Signed programmable coefficients, round-half-up, clip to the pixel range. Full valid/ready backpressure.
//  Pass-through of the aligned centre pixel and a per-beat bypass mode.
//  Sits between the line-buffer column extractor and the horizontal filter stage.
// PARAMETERS
//  DATA_WIDTH   8   unsigned pixel width
//  TAP_NUMS     3   vertical taps; odd, >=3
//  COEFF_WIDTH  14  signed two's-complement coefficient width
//  COEFF_FRAC   12  fractional bits of each coefficient; COEFF_WIDTH >= COEFF_FRAC+2
// PORTS
//  clk          in   1                      clock; all logic on the rising edge
//  rst          in   1                      reset, asynchronous, active-high
//  valid_i      in   1                      input beat valid
//  ready_o      out  1                      block can accept a beat
//  bypass_i     in   1                      per-beat: output the centre pixel unfiltered
//  data_i       in   TAP_NUMS*DATA_WIDTH    tap k = data_i[k*DATA_WIDTH +: DATA_WIDTH]; tap 0 = top row
//  coeff_load_i in   1                      load coeff_i into the active coefficient set
//  coeff_i      in   TAP_NUMS*COEFF_WIDTH   coeff k = coeff_i[k*COEFF_WIDTH +: COEFF_WIDTH]
//  valid_o      out  1                      output beat valid
//  ready_i      in   1                      downstream accepts the output beat
//  data_o       out  DATA_WIDTH             filtered, rounded, clipped pixel
//  center_o     out  DATA_WIDTH             tap TAP_NUMS/2 of the same beat
//  busy_o       out  1                      any pipeline stage holds a valid beat
//  coeff_err_o  out  1                      sticky: coeff_load_i was seen while busy_o=1
// BEHAVIOUR
//  Reset: valid_o, data_o, center_o, busy_o and coeff_err_o are 0.
//   Active coefficients reset to identity: centre tap = 1<<COEFF_FRAC, all other taps = 0.
//  Pipeline: S0 input register, S1 products, S2 sum, S3 round/clip output register. S3 drives data_o/center_o/valid_o.
//  Handshake: a beat is accepted when valid_i && ready_o.
//   Global advance en = !valid_o || ready_i. ready_o = en. All stages advance together only when en=1.
//   Bubbles advance and do not compress.
//   While valid_o=1 && ready_i=0: data_o, center_o and valid_o hold stable. No beat is lost or duplicated. Order is preserved.
//  Latency: a beat accepted in cycle T appears on valid_o in cycle T+4 when there are no stalls. Each stall cycle adds 1.
//  Sustained throughput is 1 beat/cycle while ready_i=1.
//  Arithmetic:
//   Pixel is zero-extended to DATA_WIDTH+1 bits (signed).
//   Each product is signed, DATA_WIDTH+COEFF_WIDTH+1 bits.
//   The sum grows by $clog2(TAP_NUMS) bits, so there is no internal overflow.
//   Rounding: r = (sum + (1<<(COEFF_FRAC-1))) >>> COEFF_FRAC (arithmetic shift).
//   Clip: r<0 -> 0; r>2^DATA_WIDTH-1 -> all ones; otherwise r[DATA_WIDTH-1:0].
//  Bypass: bypass_i is sampled with the beat and travels with it. At S3, data_o = centre pixel; the latency is unchanged.
//  Coefficient load:
//   coeff_load_i is honoured only in a cycle where busy_o=0 && !(valid_i && ready_o).
//   The new set applies to all later beats.
//   Otherwise the load is ignored, the active set is unchanged, and coeff_err_o goes high and stays high until rst.
//  Simultaneous events: load with a same-cycle accepted beat is the ignored case, and sets coeff_err_o.
//  Reset mid-stream: all in-flight beats are discarded and valid_o drops immediately (async). Coefficients return to identity.
//  busy_o = OR of the stage valid bits (S0..S3).
// TESTING (DATA_WIDTH=8, TAP_NUMS=3, COEFF_WIDTH=14, COEFF_FRAC=12)
//  1. After reset, no load. Stream taps {10,77,200} -> data_o=77, center_o=77, valid_o exactly 4 cycles after accept.
//  2. Load coeffs {1024,2048,1024}. Taps {10,20,30} -> 20. Coeff 2048 on tap 3 with the others 0 -> 1.5 rounds to 2.
//  3. Load coeffs {-4096,0,0}. Taps {100,0,0} -> 0 (negative clip). Load {4096,4096,4096} with taps {255,255,255} -> 255.
//  4. Stream 8 beats with values 1..8, ready_i low for cycles 3-5 -> outputs are 1..8 in order.
//     ready_o=0 during the stall and data_o is stable while stalled.
//  5. coeff_load_i pulsed while busy_o=1 -> coefficients unchanged and coeff_err_o=1 until rst.
//     An idle load then takes effect on the next beat.
//  6. Assert rst with 3 beats in flight -> valid_o=0 at once. After release, taps {1,9,3} -> 9 (identity restored).
//     With bypass_i=1 and filter coeffs loaded, output = centre pixel.

Source files
------------

// File: rtl/vfilter_ntap.sv
`default_nettype none
// ============================================================================
// Module : vfilter_ntap
// Vertical FIR stage: TAP_NUMS column pixels in, one rounded and clipped
// pixel out, with centre pass-through, per-beat bypass and valid/ready flow.
// Rev    : 1.0  initial release
// ============================================================================
module vfilter_ntap #(
    parameter int DATA_WIDTH  = 8,
    parameter int TAP_NUMS    = 3,
    parameter int COEFF_WIDTH = 14,
    parameter int COEFF_FRAC  = 12
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              valid_i,
    output logic                              ready_o,
    input  logic                              bypass_i,
    input  logic [TAP_NUMS*DATA_WIDTH-1:0]    data_i,
    input  logic                              coeff_load_i,
    input  logic [TAP_NUMS*COEFF_WIDTH-1:0]   coeff_i,
    output logic                              valid_o,
    input  logic                              ready_i,
    output logic [DATA_WIDTH-1:0]             data_o,
    output logic [DATA_WIDTH-1:0]             center_o,
    output logic                              busy_o,
    output logic                              coeff_err_o
);

    localparam int c_center = TAP_NUMS / 2;
    localparam int c_prod_w = DATA_WIDTH + COEFF_WIDTH + 1;
    localparam int c_sum_w  = c_prod_w + $clog2(TAP_NUMS);
    localparam int c_rnd_w  = c_sum_w + 1;
    localparam int c_res_w  = c_rnd_w - COEFF_FRAC;

    localparam logic [COEFF_WIDTH-1:0] c_unity =
        {{(COEFF_WIDTH-COEFF_FRAC-1){1'b0}}, 1'b1, {COEFF_FRAC{1'b0}}};
    localparam logic [TAP_NUMS-1:0][COEFF_WIDTH-1:0] c_identity =
        (TAP_NUMS*COEFF_WIDTH)'(c_unity) << (c_center*COEFF_WIDTH);
    localparam logic signed [c_rnd_w-1:0] c_half = c_rnd_w'(1) << (COEFF_FRAC-1);

    // Pipeline registers
    logic                                      s0_valid_q,  s0_valid_d;
    logic                                      s0_bypass_q, s0_bypass_d;
    logic [TAP_NUMS-1:0][DATA_WIDTH-1:0]       s0_pix_q,    s0_pix_d;

    logic                                      s1_valid_q,  s1_valid_d;
    logic                                      s1_bypass_q, s1_bypass_d;
    logic [DATA_WIDTH-1:0]                     s1_center_q, s1_center_d;
    logic [TAP_NUMS-1:0][c_prod_w-1:0]         s1_prod_q,   s1_prod_d;

    logic                                      s2_valid_q,  s2_valid_d;
    logic                                      s2_bypass_q, s2_bypass_d;
    logic [DATA_WIDTH-1:0]                     s2_center_q, s2_center_d;
    logic signed [c_sum_w-1:0]                 s2_sum_q,    s2_sum_d;

    logic                                      s3_valid_q,  s3_valid_d;
    logic [DATA_WIDTH-1:0]                     s3_data_q,   s3_data_d;
    logic [DATA_WIDTH-1:0]                     s3_center_q, s3_center_d;

    logic [TAP_NUMS-1:0][COEFF_WIDTH-1:0]      coeff_q,     coeff_d;
    logic                                      coeff_err_q, coeff_err_d;

    // Combinational datapath
    logic                                      en_w;
    logic                                      load_ok_w;
    logic [TAP_NUMS-1:0][c_prod_w-1:0]         prod_w;
    logic signed [c_sum_w-1:0]                 sum_w;
    logic signed [c_rnd_w-1:0]                 rnd_w;
    logic signed [c_res_w-1:0]                 res_w;
    logic [DATA_WIDTH-1:0]                     clip_w;

    assign en_w      = !s3_valid_q || ready_i;
    assign ready_o   = en_w;
    assign busy_o    = s0_valid_q | s1_valid_q | s2_valid_q | s3_valid_q;
    assign load_ok_w = !busy_o && !(valid_i && ready_o);

    assign valid_o     = s3_valid_q;
    assign data_o      = s3_data_q;
    assign center_o    = s3_center_q;
    assign coeff_err_o = coeff_err_q;

    // Operands are widened to the full product width so the signed multiply
    // is exact and needs no sizing rules from the surrounding context.
    genvar k;
    generate
        for (k = 0; k < TAP_NUMS; k++) begin : g_tap
            logic signed [c_prod_w-1:0] pix_ext;
            logic signed [c_prod_w-1:0] coef_ext;
            assign pix_ext   = {{(c_prod_w-DATA_WIDTH){1'b0}}, s0_pix_q[k]};
            assign coef_ext  = {{(c_prod_w-COEFF_WIDTH){coeff_q[k][COEFF_WIDTH-1]}}, coeff_q[k]};
            assign prod_w[k] = pix_ext * coef_ext;
        end
    endgenerate

    always_comb begin
        sum_w = '0;
        for (int i = 0; i < TAP_NUMS; i++) begin
            sum_w = sum_w + {{(c_sum_w-c_prod_w){s1_prod_q[i][c_prod_w-1]}}, s1_prod_q[i]};
        end
    end

    // One guard bit keeps the rounding add from wrapping at the sum extremes.
    assign rnd_w = {s2_sum_q[c_sum_w-1], s2_sum_q} + c_half;
    assign res_w = c_res_w'(rnd_w >>> COEFF_FRAC);

    always_comb begin
        if (res_w[c_res_w-1]) begin
            clip_w = '0;
        end else if (|res_w[c_res_w-2:DATA_WIDTH]) begin
            clip_w = '1;
        end else begin
            clip_w = res_w[DATA_WIDTH-1:0];
        end
    end

    always_comb begin
        s0_valid_d  = s0_valid_q;
        s0_bypass_d = s0_bypass_q;
        s0_pix_d    = s0_pix_q;
        s1_valid_d  = s1_valid_q;
        s1_bypass_d = s1_bypass_q;
        s1_center_d = s1_center_q;
        s1_prod_d   = s1_prod_q;
        s2_valid_d  = s2_valid_q;
        s2_bypass_d = s2_bypass_q;
        s2_center_d = s2_center_q;
        s2_sum_d    = s2_sum_q;
        s3_valid_d  = s3_valid_q;
        s3_data_d   = s3_data_q;
        s3_center_d = s3_center_q;
        coeff_d     = coeff_q;
        coeff_err_d = coeff_err_q;

        if (en_w) begin
            s0_valid_d  = valid_i;
            s0_bypass_d = bypass_i;
            s0_pix_d    = data_i;

            s1_valid_d  = s0_valid_q;
            s1_bypass_d = s0_bypass_q;
            s1_center_d = s0_pix_q[c_center];
            s1_prod_d   = prod_w;

            s2_valid_d  = s1_valid_q;
            s2_bypass_d = s1_bypass_q;
            s2_center_d = s1_center_q;
            s2_sum_d    = sum_w;

            s3_valid_d  = s2_valid_q;
            s3_data_d   = s2_bypass_q ? s2_center_q : clip_w;
            s3_center_d = s2_center_q;
        end

        // Coefficients only change with the pipeline empty, so every beat
        // sees one consistent set from S0 through S1.
        if (coeff_load_i) begin
            if (load_ok_w) begin
                coeff_d = coeff_i;
            end else begin
                coeff_err_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s0_valid_q  <= 1'b0;
            s0_bypass_q <= 1'b0;
            s0_pix_q    <= '0;
            s1_valid_q  <= 1'b0;
            s1_bypass_q <= 1'b0;
            s1_center_q <= '0;
            s1_prod_q   <= '0;
            s2_valid_q  <= 1'b0;
            s2_bypass_q <= 1'b0;
            s2_center_q <= '0;
            s2_sum_q    <= '0;
            s3_valid_q  <= 1'b0;
            s3_data_q   <= '0;
            s3_center_q <= '0;
            coeff_q     <= c_identity;
            coeff_err_q <= 1'b0;
        end else begin
            s0_valid_q  <= s0_valid_d;
            s0_bypass_q <= s0_bypass_d;
            s0_pix_q    <= s0_pix_d;
            s1_valid_q  <= s1_valid_d;
            s1_bypass_q <= s1_bypass_d;
            s1_center_q <= s1_center_d;
            s1_prod_q   <= s1_prod_d;
            s2_valid_q  <= s2_valid_d;
            s2_bypass_q <= s2_bypass_d;
            s2_center_q <= s2_center_d;
            s2_sum_q    <= s2_sum_d;
            s3_valid_q  <= s3_valid_d;
            s3_data_q   <= s3_data_d;
            s3_center_q <= s3_center_d;
            coeff_q     <= coeff_d;
            coeff_err_q <= coeff_err_d;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_vfilter_ntap.sv
`default_nettype none
// ============================================================================
// Module : tb_vfilter_ntap
// Directed self-checking bench for vfilter_ntap (8-bit, 3 taps, Q2.12 coeffs).
// Rev    : 1.0  initial release
// ============================================================================
module tb_vfilter_ntap;

    logic        clk;
    logic        rst;
    logic        valid_i;
    logic        ready_o;
    logic        bypass_i;
    logic [23:0] data_i;
    logic        coeff_load_i;
    logic [41:0] coeff_i;
    logic        valid_o;
    logic        ready_i;
    logic [7:0]  data_o;
    logic [7:0]  center_o;
    logic        busy_o;
    logic        coeff_err_o;

    int n_tests = 0;
    int n_fail  = 0;

    vfilter_ntap #(
        .DATA_WIDTH  (8),
        .TAP_NUMS    (3),
        .COEFF_WIDTH (14),
        .COEFF_FRAC  (12)
    ) u_dut (
        .clk          (clk),
        .rst          (rst),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .bypass_i     (bypass_i),
        .data_i       (data_i),
        .coeff_load_i (coeff_load_i),
        .coeff_i      (coeff_i),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .data_o       (data_o),
        .center_o     (center_o),
        .busy_o       (busy_o),
        .coeff_err_o  (coeff_err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic load_coeffs(input logic [13:0] c0, input logic [13:0] c1, input logic [13:0] c2);
        coeff_i      = {c2, c1, c0};
        coeff_load_i = 1'b1;
        @(posedge clk); #1;
        coeff_load_i = 1'b0;
    endtask

    // One isolated beat; optionally pulses coeff_load_i the cycle after accept.
    task automatic run_one(input string tag, input logic [7:0] t0, input logic [7:0] t1,
                           input logic [7:0] t2, input logic byp, input logic mid_load,
                           input logic [7:0] exp_d, input logic [7:0] exp_c);
        int lat;
        data_i   = {t2, t1, t0};
        bypass_i = byp;
        valid_i  = 1'b1;
        ready_i  = 1'b1;
        #1;
        check_eq({tag, "_rdy"}, 32'(ready_o), 32'd1);
        @(posedge clk); #1;
        valid_i  = 1'b0;
        bypass_i = 1'b0;
        if (mid_load) coeff_load_i = 1'b1;
        lat = 1;
        while (!valid_o && lat < 20) begin
            @(posedge clk); #1;
            coeff_load_i = 1'b0;
            lat++;
        end
        coeff_load_i = 1'b0;
        check_eq({tag, "_lat"}, 32'(lat), 32'd4);
        check_eq({tag, "_data"}, 32'(data_o), 32'(exp_d));
        check_eq({tag, "_ctr"}, 32'(center_o), 32'(exp_c));
        @(posedge clk); #1;
        check_eq({tag, "_idle"}, 32'(busy_o), 32'd0);
    endtask

    initial begin
        int sent;
        int rcv;
        int prev;
        int have_prev;
        int wait_n;
        logic acc;

        rst          = 1'b1;
        valid_i      = 1'b0;
        bypass_i     = 1'b0;
        data_i       = '0;
        coeff_load_i = 1'b0;
        coeff_i      = '0;
        ready_i      = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        @(posedge clk); #1;

        check_eq("rst_valid", 32'(valid_o), 32'd0);
        check_eq("rst_data", 32'(data_o), 32'd0);
        check_eq("rst_center", 32'(center_o), 32'd0);
        check_eq("rst_busy", 32'(busy_o), 32'd0);
        check_eq("rst_err", 32'(coeff_err_o), 32'd0);

        // Identity coefficients after reset
        run_one("ident", 8'd10, 8'd77, 8'd200, 1'b0, 1'b0, 8'd77, 8'd77);

        // 0.25/0.5/0.25 smoothing: 10*.25+20*.5+30*.25 = 20
        load_coeffs(14'd1024, 14'd2048, 14'd1024);
        run_one("smooth", 8'd10, 8'd20, 8'd30, 1'b0, 1'b0, 8'd20, 8'd20);
        // 3*0.5 = 1.5 -> 2 and 5*0.5 = 2.5 -> 3 (round half up)
        load_coeffs(14'd0, 14'd2048, 14'd0);
        run_one("half15", 8'd0, 8'd3, 8'd0, 1'b0, 1'b0, 8'd2, 8'd3);
        run_one("half25", 8'd0, 8'd5, 8'd0, 1'b0, 1'b0, 8'd3, 8'd5);

        // 14'h3000 is -4096 (-1.0): -100 clips to 0
        load_coeffs(14'h3000, 14'd0, 14'd0);
        run_one("negclip", 8'd100, 8'd0, 8'd0, 1'b0, 1'b0, 8'd0, 8'd0);
        load_coeffs(14'd4096, 14'd4096, 14'd4096);
        run_one("posclip", 8'd255, 8'd255, 8'd255, 1'b0, 1'b0, 8'd255, 8'd255);
        // 200 + 100 - 50 = 250
        load_coeffs(14'd4096, 14'd4096, 14'h3000);
        run_one("mixsign", 8'd200, 8'd100, 8'd50, 1'b0, 1'b0, 8'd250, 8'd100);

        // Streaming with downstream stall in cycles 3..5
        load_coeffs(14'd0, 14'd4096, 14'd0);
        sent      = 0;
        rcv       = 0;
        prev      = 0;
        have_prev = 0;
        for (int c = 0; c < 60 && rcv < 8; c++) begin
            ready_i = !(c >= 3 && c <= 5);
            valid_i = (sent < 8);
            data_i  = {8'd0, 8'(sent + 1), 8'd0};
            #1;
            acc = valid_i && ready_o;
            if (valid_o && ready_i) begin
                check_eq("stream_data", 32'(data_o), 32'(rcv + 1));
                rcv++;
            end else if (valid_o) begin
                check_eq("stall_rdy", 32'(ready_o), 32'd0);
                if (have_prev != 0) check_eq("stall_hold", 32'(data_o), 32'(prev));
                prev      = int'(data_o);
                have_prev = 1;
            end
            @(posedge clk); #1;
            if (acc) sent++;
        end
        valid_i = 1'b0;
        ready_i = 1'b1;
        check_eq("stream_count", 32'(rcv), 32'd8);
        check_eq("stall_seen", 32'(have_prev), 32'd1);
        @(posedge clk); #1;

        // Load while busy is ignored and latches the error flag
        check_eq("err_before", 32'(coeff_err_o), 32'd0);
        coeff_i = {14'd0, 14'd2048, 14'd0};
        run_one("busyload", 8'd0, 8'd50, 8'd0, 1'b0, 1'b1, 8'd50, 8'd50);
        check_eq("err_set", 32'(coeff_err_o), 32'd1);
        load_coeffs(14'd0, 14'd2048, 14'd0);
        run_one("idleload", 8'd0, 8'd10, 8'd0, 1'b0, 1'b0, 8'd5, 8'd10);
        check_eq("err_sticky", 32'(coeff_err_o), 32'd1);

        // Three beats in flight with a stalled output, then async reset
        ready_i = 1'b0;
        for (int b = 0; b < 3; b++) begin
            valid_i = 1'b1;
            data_i  = {8'd0, 8'(b + 21), 8'd0};
            @(posedge clk); #1;
        end
        valid_i = 1'b0;
        wait_n  = 0;
        while (!valid_o && wait_n < 10) begin
            @(posedge clk); #1;
            wait_n++;
        end
        check_eq("pre_rst_valid", 32'(valid_o), 32'd1);
        check_eq("pre_rst_busy", 32'(busy_o), 32'd1);
        #1;
        rst = 1'b1;
        #1;
        check_eq("async_valid", 32'(valid_o), 32'd0);
        check_eq("async_busy", 32'(busy_o), 32'd0);
        check_eq("async_err", 32'(coeff_err_o), 32'd0);
        @(posedge clk); #1;
        rst     = 1'b0;
        ready_i = 1'b1;
        @(posedge clk); #1;

        run_one("ident2", 8'd1, 8'd9, 8'd3, 1'b0, 1'b0, 8'd9, 8'd9);

        // 100*.25 + 37*.5 + 200*.25 = 93.5 -> 94; bypass returns the centre
        load_coeffs(14'd1024, 14'd2048, 14'd1024);
        run_one("bypass", 8'd100, 8'd37, 8'd200, 1'b1, 1'b0, 8'd37, 8'd37);
        run_one("nobypass", 8'd100, 8'd37, 8'd200, 1'b0, 1'b0, 8'd94, 8'd37);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
